nios_sd_loader_status_in: RTL and testbench

Avalon-MM slave input port carrying status bits from the ZX/SD loader fabric into the Nios II. It is the inbound counterpart of the loader's 16-bit output ports. Per bit, it provides:
- input synchronisation,
- edge detection and sticky edge capture,
- a maskable, level-sensitive interrupt to the CPU.

Sits on the Nios data master alongside the loader's other PIO-style ports.

---
 rtl/nios_sd_loader_status_in_if.sv | 24 ++
 rtl/nios_sd_loader_status_in.sv | 135 +++++++++++++
 tb/tb_nios_sd_loader_status_in.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_sd_loader_status_in_if.sv
// Avalon-MM slave bus bundle for the loader status input port.
interface nios_sd_loader_status_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios_sd_loader_status_in.sv
// Loader status input PIO: synchronises in_port, captures edges stickily and raises a maskable irq.
// Define NIOS_SD_LOADER_STATUS_IN_BITCLR_EN to clear EDGE_CAPTURE per written bit; otherwise any write clears all bits.
module nios_sd_loader_status_in #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  nios_sd_loader_status_in_if.slave        bus_s,
  input  logic [WIDTH-1:0]                 in_port,
  output logic                             irq
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_CYCLES);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] sync_val_s;
  logic [WIDTH-1:0] edge_raw_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] rd_val_s;
  logic [31:0]      rd_ext_s;
  logic             armed_s;
  logic             wr_s;
  logic             wr_mask_s;
  logic             wr_cap_s;

  // State register for all flops, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= {(SYNC_STAGES*WIDTH){1'b0}};
      prev_q    <= {WIDTH{1'b0}};
      mask_q    <= {WIDTH{1'b0}};
      cap_q     <= {WIDTH{1'b0}};
      arm_cnt_q <= {ARM_W{1'b0}};
      irq_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      arm_cnt_q <= arm_cnt_d;
      irq_q     <= irq_d;
    end
  end

  // Arming counter next state: counts up once after reset, then parks at ARM_DONE.
  always_comb begin
    if (arm_cnt_q == ARM_DONE) begin
      arm_cnt_d = arm_cnt_q;
    end else begin
      arm_cnt_d = arm_cnt_q + ARM_W'(1);
    end
  end

  // Arming output decode.
  always_comb begin
    armed_s = (arm_cnt_q == ARM_DONE);
  end

  // Synchroniser shift and edge detection.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], in_port};
    sync_val_s = sync_q[SYNC_STAGES-1];
    prev_d     = sync_val_s;
    case (EDGE_TYPE)
      32'd0:   edge_raw_s = sync_val_s & ~prev_q;
      32'd1:   edge_raw_s = ~sync_val_s & prev_q;
      32'd2:   edge_raw_s = sync_val_s ^ prev_q;
      default: edge_raw_s = sync_val_s & ~prev_q;
    endcase
    if (armed_s) begin
      edge_s = edge_raw_s;
    end else begin
      edge_s = {WIDTH{1'b0}};
    end
  end

  // Register writes, capture update (a new edge beats a same-cycle clear) and irq.
  always_comb begin
    wr_s      = bus_s.chipselect & ~bus_s.write_n;
    wr_mask_s = wr_s & (bus_s.address == ADDR_MASK);
    wr_cap_s  = wr_s & (bus_s.address == ADDR_CAP);
    if (wr_cap_s) begin
`ifdef NIOS_SD_LOADER_STATUS_IN_BITCLR_EN
      clr_s = bus_s.writedata[WIDTH-1:0];
`else
      clr_s = {WIDTH{1'b1}};
`endif
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    if (wr_mask_s) begin
      mask_d = bus_s.writedata[WIDTH-1:0];
    end else begin
      mask_d = mask_q;
    end
    cap_d = (cap_q & ~clr_s) | edge_s;
    irq_d = |(cap_q & mask_q);
  end

  // Zero-latency read mux, zero-extended to the bus width.
  always_comb begin
    rd_val_s = {WIDTH{1'b0}};
    if (bus_s.chipselect) begin
      case (bus_s.address)
        ADDR_DATA: rd_val_s = sync_val_s;
        ADDR_MASK: rd_val_s = mask_q;
        ADDR_CAP:  rd_val_s = cap_q;
        default:   rd_val_s = {WIDTH{1'b0}};
      endcase
    end else begin
      rd_val_s = {WIDTH{1'b0}};
    end
    rd_ext_s              = 32'd0;
    rd_ext_s[WIDTH-1:0]   = rd_val_s;
  end

  assign bus_s.readdata = rd_ext_s;
  assign irq            = irq_q;

endmodule

// File: tb/tb_nios_sd_loader_status_in.sv
// Bench for nios_sd_loader_status_in: a rising-edge and an any-edge instance share one stimulus
// and are checked against directed expectations and a cycle-level behavioural model.
module tb_nios_sd_loader_status_in;

`ifdef NIOS_SD_LOADER_STATUS_IN_BITCLR_EN
  localparam bit BITCLR = 1'b1;
`else
  localparam bit BITCLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [15:0] in_port;
  logic        irq_a, irq_b;
  logic [31:0] rd_a, rd_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  nios_sd_loader_status_in_if bus_a ();
  nios_sd_loader_status_in_if bus_b ();

  assign bus_a.address = address;  assign bus_b.address = address;
  assign bus_a.chipselect = chipselect;  assign bus_b.chipselect = chipselect;
  assign bus_a.write_n = write_n;  assign bus_b.write_n = write_n;
  assign bus_a.writedata = writedata;  assign bus_b.writedata = writedata;
  assign rd_a = bus_a.readdata;
  assign rd_b = bus_b.readdata;

  nios_sd_loader_status_in #(.WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus_s(bus_a), .in_port(in_port), .irq(irq_a));
  nios_sd_loader_status_in #(.WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus_s(bus_b), .in_port(in_port), .irq(irq_b));

  // Reference model: index 0 = rising-edge instance, 1 = any-edge instance.
  logic [15:0] m_hist[$];
  logic [15:0] m_s, m_prev, m_mask;
  logic [15:0] m_cap[2];
  logic        m_irq[2];
  int          m_n;

  function automatic logic [15:0] m_edge(int k, logic [15:0] s, logic [15:0] p);
    if (k == 0) return s & ~p;
    return s ^ p;
  endfunction

  function automatic logic [31:0] m_rd(int k, logic cs, logic [1:0] a);
    if (!cs) return 32'd0;
    case (a)
      2'd0:    return {16'd0, m_s};
      2'd2:    return {16'd0, m_mask};
      2'd3:    return {16'd0, m_cap[k]};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hist = {};
      m_s = 16'd0; m_prev = 16'd0; m_mask = 16'd0; m_n = 0;
      for (int k = 0; k < 2; k++) begin m_cap[k] = 16'd0; m_irq[k] = 1'b0; end
    end else begin
      logic [15:0] clr;
      logic        wr;
      wr  = chipselect && !write_n;
      clr = 16'd0;
      if (wr && address == 2'd3) clr = BITCLR ? writedata[15:0] : 16'hFFFF;
      for (int k = 0; k < 2; k++) begin
        m_irq[k] = |(m_cap[k] & m_mask);
        m_cap[k] = (m_cap[k] & ~clr) | ((m_n >= 3) ? m_edge(k, m_s, m_prev) : 16'd0);
      end
      if (wr && address == 2'd2) m_mask = writedata[15:0];
      m_prev = m_s;
      m_hist.push_back(in_port);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      m_s = (m_hist.size() >= 2) ? m_hist[m_hist.size()-2] : 16'd0;
      if (m_n < 1000) m_n++;
    end
  end

  task automatic set_rd(input logic [1:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    write_n = 1'b1; chipselect = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_port = 16'h00FF; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    if (rd_a !== 32'd0 || irq_a !== 1'b0) begin errors++;
      $display("FAIL reset_idle: rd=%h irq=%b expected 0/0", rd_a, irq_a); end
    checks++;
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    set_rd(2'd0);
    if (rd_a !== 32'h0000_00FF || rd_b !== 32'h0000_00FF) begin errors++;
      $display("FAIL reset_data: a=%h b=%h expected 000000ff", rd_a, rd_b); end
    checks++;
    set_rd(2'd3);
    if (rd_a !== 32'd0 || rd_b !== 32'd0) begin errors++;
      $display("FAIL reset_arm_cap: a=%h b=%h expected 0", rd_a, rd_b); end
    checks++;
    if (irq_a !== 1'b0 || irq_b !== 1'b0) begin errors++;
      $display("FAIL reset_arm_irq: a=%b b=%b expected 0", irq_a, irq_b); end
    checks++;
    chipselect = 1'b0; address = 2'd0; #1;
    if (rd_a !== 32'd0) begin errors++;
      $display("FAIL no_cs_read: got %h expected 0", rd_a); end
    checks++;
  endtask

  task automatic test_rise_irq();
    in_port = 16'h0000;
    repeat (4) @(negedge clk);
    bus_write(2'd3, 32'h0000_FFFF);
    bus_write(2'd2, 32'h0000_0001);
    in_port = 16'h0001;
    @(negedge clk);
    set_rd(2'd0);
    if (rd_a !== 32'd0) begin errors++; $display("FAIL rise_data_e1: got %h expected 0", rd_a); end
    checks++;
    @(negedge clk);
    set_rd(2'd0);
    if (rd_a !== 32'd1) begin errors++; $display("FAIL rise_data_e2: got %h expected 1", rd_a); end
    checks++;
    set_rd(2'd3);
    if (rd_a !== 32'd0) begin errors++; $display("FAIL rise_cap_e2: got %h expected 0", rd_a); end
    checks++;
    @(negedge clk);
    set_rd(2'd3);
    if (rd_a !== 32'd1 || rd_b !== 32'd1) begin errors++;
      $display("FAIL rise_cap_e3: a=%h b=%h expected 00000001", rd_a, rd_b); end
    checks++;
    if (irq_a !== 1'b0) begin errors++; $display("FAIL rise_irq_e3: got %b expected 0", irq_a); end
    checks++;
    @(negedge clk);
    if (irq_a !== 1'b1 || irq_b !== 1'b1) begin errors++;
      $display("FAIL rise_irq_e4: a=%b b=%b expected 1", irq_a, irq_b); end
    checks++;
  endtask

  task automatic test_mask_late();
    bus_write(2'd2, 32'd0);
    in_port = 16'h0000;
    repeat (4) @(negedge clk);
    bus_write(2'd3, 32'h0000_FFFF);
    in_port = 16'h0001;
    repeat (4) @(negedge clk);
    set_rd(2'd3);
    if (rd_a !== 32'd1) begin errors++; $display("FAIL masked_cap: got %h expected 1", rd_a); end
    checks++;
    if (irq_a !== 1'b0) begin errors++; $display("FAIL masked_irq: got %b expected 0", irq_a); end
    checks++;
    bus_write(2'd2, 32'd1);
    if (irq_a !== 1'b0) begin errors++; $display("FAIL unmask_write_edge: got %b expected 0", irq_a); end
    checks++;
    @(negedge clk);
    if (irq_a !== 1'b1 || irq_b !== m_irq[1]) begin errors++;
      $display("FAIL unmask_next_cycle: a=%b b=%b expected 1/%b", irq_a, irq_b, m_irq[1]); end
    checks++;
  endtask

  task automatic test_clear();
    in_port = 16'h0003;
    repeat (4) @(negedge clk);
    set_rd(2'd3);
    if (rd_a !== 32'd3) begin errors++; $display("FAIL clr_pre: got %h expected 3", rd_a); end
    checks++;
    bus_write(2'd3, 32'd1);
    set_rd(2'd3);
    if (rd_a !== (BITCLR ? 32'd2 : 32'd0) || rd_b !== (BITCLR ? 32'd2 : 32'd0)) begin errors++;
      $display("FAIL clr_write1: a=%h b=%h expected %h", rd_a, rd_b, BITCLR ? 32'd2 : 32'd0); end
    checks++;
    @(negedge clk);
    if (irq_a !== 1'b0) begin errors++; $display("FAIL clr_irq_drop: got %b expected 0", irq_a); end
    checks++;
    bus_write(2'd2, 32'd2);
    @(negedge clk);
    if (irq_a !== BITCLR) begin errors++;
      $display("FAIL clr_irq_follow: got %b expected %b", irq_a, BITCLR); end
    checks++;
  endtask

  task automatic test_set_wins();
    in_port = 16'h0023;
    @(negedge clk);
    @(negedge clk);
    bus_write(2'd3, 32'h0000_0020);
    set_rd(2'd3);
    if ((rd_a & 32'h20) !== 32'h20 || (rd_b & 32'h20) !== 32'h20) begin errors++;
      $display("FAIL set_wins_bit5: a=%h b=%h expected bit5 set", rd_a, rd_b); end
    checks++;
    if (rd_a !== m_rd(0, 1'b1, 2'd3)) begin errors++;
      $display("FAIL set_wins_full: got %h expected %h", rd_a, m_rd(0, 1'b1, 2'd3)); end
    checks++;
  endtask

  task automatic test_any_edge();
    in_port = 16'h002B;
    repeat (4) @(negedge clk);
    bus_write(2'd3, 32'h0000_FFFF);
    in_port = 16'h0023;
    repeat (4) @(negedge clk);
    set_rd(2'd3);
    if (rd_b !== 32'h8 || rd_a !== 32'h0) begin errors++;
      $display("FAIL any_fall: b=%h a=%h expected 8/0", rd_b, rd_a); end
    checks++;
    bus_write(2'd3, 32'h0000_FFFF);
    set_rd(2'd3);
    if (rd_b !== 32'h0) begin errors++; $display("FAIL any_clear: got %h expected 0", rd_b); end
    checks++;
    in_port = 16'h002B;
    repeat (4) @(negedge clk);
    set_rd(2'd3);
    if (rd_b !== 32'h8 || rd_a !== 32'h8) begin errors++;
      $display("FAIL any_rise: b=%h a=%h expected 8/8", rd_b, rd_a); end
    checks++;
    bus_write(2'd2, 32'h8);
    repeat (2) @(negedge clk);
    if (irq_a !== 1'b1 || irq_b !== 1'b1) begin errors++;
      $display("FAIL pre_reset_irq: a=%b b=%b expected 1", irq_a, irq_b); end
    checks++;
    reset_n = 1'b0;
    #1;
    if (irq_a !== 1'b0 || irq_b !== 1'b0) begin errors++;
      $display("FAIL midreset_irq: a=%b b=%b expected 0", irq_a, irq_b); end
    checks++;
    for (int a = 0; a < 4; a++) begin
      set_rd(2'(a));
      if (rd_a !== 32'd0 || rd_b !== 32'd0) begin errors++;
        $display("FAIL midreset_reg%0d: a=%h b=%h expected 0", a, rd_a, rd_b); end
      checks++;
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    in_port = 16'($urandom);
    chipselect = 1'b0; write_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      chipselect = ($urandom_range(0, 3) != 0);
      write_n = 1'b1;
      address = 2'($urandom_range(0, 3));
      #1;
      if (rd_a !== m_rd(0, chipselect, address) || rd_b !== m_rd(1, chipselect, address)) begin
        errors++;
        $display("FAIL rand_read[%0d] addr=%0d: a=%h b=%h expected %h/%h", i, address,
                 rd_a, rd_b, m_rd(0, chipselect, address), m_rd(1, chipselect, address));
      end
      checks++;
      if (irq_a !== m_irq[0] || irq_b !== m_irq[1]) begin errors++;
        $display("FAIL rand_irq[%0d]: a=%b b=%b expected %b/%b", i, irq_a, irq_b, m_irq[0], m_irq[1]);
      end
      checks++;
      if ($urandom_range(0, 2) == 0) in_port = in_port ^ (16'd1 << $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        chipselect = 1'b1; write_n = 1'b0;
        address = 2'($urandom_range(0, 3));
        writedata = $urandom;
      end
    end
    @(negedge clk);
    write_n = 1'b1; chipselect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rise_irq();
    test_mask_late();
    test_clear();
    test_set_wins();
    test_any_edge();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
